// File: rtl/bus_sched_pkg.sv
// ============================================================================
// Module : bus_sched_pkg
// Brief  : Shared types, constants and helpers for the bus round-robin scheduler.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package bus_sched_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        POP  = 2'd1,
        PUSH = 2'd2
    } sched_state_e;

    localparam logic [7:0]  BCAST_ID_DEF = 8'hFF;
    localparam int unsigned MAX_PKT_W    = 64;
    localparam int unsigned MAX_ID_W     = 32;

    // Extracts the destination field from the top id_w bits of a pkt_w-bit packet.
    function automatic logic [MAX_ID_W-1:0] get_dest(
        input logic [MAX_PKT_W-1:0] pkt,
        input int unsigned          pkt_w,
        input int unsigned          id_w
    );
        logic [MAX_PKT_W-1:0] sh;
        logic [MAX_PKT_W-1:0] msk;
        sh  = pkt >> (pkt_w - id_w);
        msk = (MAX_PKT_W'(1) << id_w) - MAX_PKT_W'(1);
        sh  = sh & msk;
        return sh[MAX_ID_W-1:0];
    endfunction

endpackage

`default_nettype wire

// File: rtl/rr_picker.sv
// ============================================================================
// Module : rr_picker
// Brief  : Combinational rotated priority encoder; first request at or after ptr.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_picker #(
    parameter int unsigned N     = 8,
    parameter int unsigned IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             gnt_vld
);

    logic [IDX_W-1:0] w_idx;
    logic             w_found;

    always_comb begin
        gnt_idx = '0;
        w_idx   = '0;
        w_found = 1'b0;
        for (int unsigned k = 0; k < N; k++) begin
            w_idx = IDX_W'((32'(ptr) + k) % N);
            if (!w_found && req[w_idx]) begin
                w_found = 1'b1;
                gnt_idx = w_idx;
            end
        end
    end

    assign gnt_vld = |req;

endmodule

`default_nettype wire

// File: rtl/bus_rr_sched.sv
// ============================================================================
// Module : bus_rr_sched
// Brief  : Round-robin packet bus controller (IDLE -> POP -> PUSH per packet).
//          Optional BUS_SCHED_STATS_EN adds delivered/dropped packet counters.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bus_rr_sched
    import bus_sched_pkg::*;
#(
    parameter int unsigned     PCKG_SZ  = 16,
    parameter int unsigned     DRVRS    = 8,
    parameter int unsigned     ID_W     = 8,
    parameter logic [ID_W-1:0] BCAST_ID = ID_W'(BCAST_ID_DEF)
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [DRVRS-1:0]                 pndng,
    input  logic [DRVRS-1:0][PCKG_SZ-1:0]    D_pop,
    output logic [DRVRS-1:0]                 pop,
    output logic [DRVRS-1:0]                 push,
    output logic [DRVRS-1:0][PCKG_SZ-1:0]    D_push,
    output logic [$clog2(DRVRS)-1:0]         grant_id,
    output logic                             busy
`ifdef BUS_SCHED_STATS_EN
    ,
    output logic [15:0]                      pkt_cnt,
    output logic [15:0]                      drop_cnt
`endif
);

    localparam int unsigned c_idx_w = $clog2(DRVRS);

    sched_state_e         state_q, state_d;
    logic [c_idx_w-1:0]   grant_q, grant_d;
    logic [c_idx_w-1:0]   rr_ptr_q, rr_ptr_d;
    logic [PCKG_SZ-1:0]   pkt_q, pkt_d;

    logic [c_idx_w-1:0]   w_pick_idx;
    logic                 w_pick_vld;
    logic [ID_W-1:0]      w_dest;
    logic [DRVRS-1:0]     w_src_oh;
    logic [DRVRS-1:0]     w_push_mask;
    logic                 w_deliver;

    rr_picker #(
        .N     (DRVRS),
        .IDX_W (c_idx_w)
    ) u_picker (
        .req     (pndng),
        .ptr     (rr_ptr_q),
        .gnt_idx (w_pick_idx),
        .gnt_vld (w_pick_vld)
    );

    assign w_dest   = ID_W'(get_dest(MAX_PKT_W'(pkt_q), PCKG_SZ, ID_W));
    assign w_src_oh = DRVRS'(1) << grant_q;

    // Broadcast never loops back; unicast to self or out-of-range is dropped.
    always_comb begin
        w_push_mask = '0;
        if (w_dest == BCAST_ID) begin
            w_push_mask = ~w_src_oh;
        end else if ((32'(w_dest) < DRVRS) && (w_dest != ID_W'(grant_q))) begin
            w_push_mask = DRVRS'(1) << w_dest;
        end
    end

    assign w_deliver = |w_push_mask;

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        rr_ptr_d = rr_ptr_q;
        pkt_d    = pkt_q;
        pop      = '0;
        push     = '0;
        unique case (state_q)
            IDLE: begin
                if (w_pick_vld) begin
                    grant_d = w_pick_idx;
                    state_d = POP;
                end
            end
            POP: begin
                pop     = w_src_oh;
                pkt_d   = D_pop[grant_q];
                state_d = PUSH;
            end
            PUSH: begin
                push     = w_push_mask;
                rr_ptr_d = (32'(grant_q) == DRVRS - 1) ? '0 : grant_q + c_idx_w'(1);
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            grant_q  <= '0;
            rr_ptr_q <= '0;
            pkt_q    <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            rr_ptr_q <= rr_ptr_d;
            pkt_q    <= pkt_d;
        end
    end

    assign D_push   = {DRVRS{pkt_q}};
    assign grant_id = grant_q;
    assign busy     = (state_q != IDLE);

`ifdef BUS_SCHED_STATS_EN
    logic [15:0] pkt_cnt_q;
    logic [15:0] drop_cnt_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pkt_cnt_q  <= '0;
            drop_cnt_q <= '0;
        end else if (state_q == PUSH) begin
            if (w_deliver) begin
                if (pkt_cnt_q != 16'hFFFF) pkt_cnt_q <= pkt_cnt_q + 16'd1;
            end else begin
                if (drop_cnt_q != 16'hFFFF) drop_cnt_q <= drop_cnt_q + 16'd1;
            end
        end
    end

    assign pkt_cnt  = pkt_cnt_q;
    assign drop_cnt = drop_cnt_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_bus_rr_sched.sv
// ============================================================================
// Module : tb_bus_rr_sched
// Brief  : Directed self-checking bench for bus_rr_sched (8 drivers, 16-bit packets).
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bus_rr_sched;

    logic              clk;
    logic              reset;
    logic [7:0]        pndng;
    logic [7:0][15:0]  D_pop;
    logic [7:0]        pop;
    logic [7:0]        push;
    logic [7:0][15:0]  D_push;
    logic [2:0]        grant_id;
    logic              busy;
`ifdef BUS_SCHED_STATS_EN
    logic [15:0]       pkt_cnt;
    logic [15:0]       drop_cnt;
`endif

    int n_checks = 0;
    int n_err    = 0;

    bus_rr_sched dut (
        .clk      (clk),
        .reset    (reset),
        .pndng    (pndng),
        .D_pop    (D_pop),
        .pop      (pop),
        .push     (push),
        .D_push   (D_push),
        .grant_id (grant_id),
        .busy     (busy)
`ifdef BUS_SCHED_STATS_EN
        ,
        .pkt_cnt  (pkt_cnt),
        .drop_cnt (drop_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b0;
        pndng = 8'hFF;
        for (int i = 0; i < 8; i++) D_pop[i] = {8'((i + 1) % 8), 8'(i)};

        // Reset held with every driver pending
        repeat (3) tick();
        chk("rst_pop",    32'(pop),      32'h0);
        chk("rst_push",   32'(push),     32'h0);
        chk("rst_busy",   32'(busy),     32'h0);
        chk("rst_grant",  32'(grant_id), 32'h0);
        chk("rst_dpush",  32'(D_push[0]), 32'h0);
`ifdef BUS_SCHED_STATS_EN
        chk("rst_pktcnt",  32'(pkt_cnt),  32'h0);
        chk("rst_dropcnt", 32'(drop_cnt), 32'h0);
`endif
        reset = 1'b1;
        tick();

        // All pending, each addressed to the next driver: order 0..7,0
        for (int k = 0; k < 9; k++) begin
            int src;
            int dst;
            src = k % 8;
            dst = (src + 1) % 8;
            chk($sformatf("rr%0d_pop", k),   32'(pop),      32'(8'h01 << src));
            chk($sformatf("rr%0d_grant", k), 32'(grant_id), 32'(src));
            chk($sformatf("rr%0d_busy", k),  32'(busy),     32'h1);
            if (k == 8) pndng = 8'h00;
            tick();
            chk($sformatf("rr%0d_push", k),  32'(push),     32'(8'h01 << dst));
            chk($sformatf("rr%0d_pop0", k),  32'(pop),      32'h0);
            chk($sformatf("rr%0d_data", k),  32'(D_push[dst]), 32'({8'(dst), 8'(src)}));
            tick();
            chk($sformatf("rr%0d_idle", k),  32'({pop, push}), 32'h0);
            tick();
        end
        chk("rr_quiet_busy", 32'(busy), 32'h0);

        // Unicast from driver 2 to driver 5
        D_pop[2] = 16'h05AB;
        pndng    = 8'h04;
        tick();
        chk("uc_pop",   32'(pop),      32'h04);
        chk("uc_grant", 32'(grant_id), 32'h2);
        pndng = 8'h00;
        tick();
        chk("uc_push",  32'(push),      32'h20);
        chk("uc_data",  32'(D_push[5]), 32'h05AB);
        tick();
        chk("uc_done",  32'(push),      32'h0);

        // Broadcast from driver 3
        D_pop[3] = 16'hFF12;
        pndng    = 8'h08;
        tick();
        chk("bc_pop",   32'(pop),  32'h08);
        pndng = 8'h00;
        tick();
        chk("bc_push",  32'(push), 32'hF7);
        chk("bc_data",  32'(D_push[0]), 32'hFF12);
        tick();
        chk("bc_once",  32'(push), 32'h0);
        chk("bc_busy",  32'(busy), 32'h0);

        // Drops: driver 1 -> id 9, driver 4 -> itself; pointer is at 4
        D_pop[1] = 16'h0934;
        D_pop[4] = 16'h0433;
        pndng    = 8'h12;
        tick();
        chk("dr4_pop",  32'(pop),  32'h10);
        pndng = 8'h02;
        tick();
        chk("dr4_push", 32'(push), 32'h0);
        chk("dr4_busy", 32'(busy), 32'h1);
        tick();
        tick();
        chk("dr1_pop",  32'(pop),  32'h02);
        pndng = 8'h00;
        tick();
        chk("dr1_push", 32'(push), 32'h0);
        tick();
`ifdef BUS_SCHED_STATS_EN
        chk("pkt_cnt",  32'(pkt_cnt),  32'd11);
        chk("drop_cnt", 32'(drop_cnt), 32'd2);
`endif

        // Reset asserted mid-POP
        pndng = 8'h04;
        tick();
        chk("mr_pop_before", 32'(pop), 32'h04);
        #2 reset = 1'b0;
        #1;
        chk("mr_pop_async",  32'(pop),      32'h0);
        chk("mr_busy_async", 32'(busy),     32'h0);
        chk("mr_grant",      32'(grant_id), 32'h0);
        pndng = 8'h00;
        tick();
        chk("mr_no_push",    32'(push),     32'h0);
`ifdef BUS_SCHED_STATS_EN
        chk("mr_pktcnt",     32'(pkt_cnt),  32'h0);
`endif
        tick();
        reset = 1'b1;
        // Pointer back at 0 picks driver 0 ahead of driver 7
        pndng = 8'h81;
        tick();
        chk("post_pop",   32'(pop),      32'h01);
        chk("post_grant", 32'(grant_id), 32'h0);
        pndng = 8'h00;
        tick();
        chk("post_push",  32'(push),     32'h02);
        tick();
        chk("post_idle",  32'(busy),     32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/bus_rr_sched.md
Name: bus_rr_sched

Overview:
- Round-robin scheduler for the shared packet bus between DRVRS FIFO-backed drivers.
- Picks one pending source, pops one packet from it, decodes the destination ID in the packet MSBs, then pushes to one destination or broadcasts to all others.
- Sits between the per-driver FIFO interfaces (pndng/pop/D_pop in, push/D_push out) and acts as the bus controller.

Parameters:
- PCKG_SZ, 16, packet width in bits.
- DRVRS, 8, number of drivers on the bus (2..16).
- ID_W, 8, destination ID field width; the ID occupies packet bits [PCKG_SZ-1 -: ID_W].
- BCAST_ID, 8'hFF, destination value meaning broadcast.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset (asserted at 0).
- pndng  in  DRVRS  bit i = 1 means driver i FIFO is non-empty.
- D_pop  in  DRVRS x PCKG_SZ  head-of-FIFO data per driver; valid while pndng[i] = 1.
- pop  out  DRVRS  one-cycle pop strobe to a source FIFO.
- push  out  DRVRS  one-cycle push strobe to destination(s).
- D_push  out  DRVRS x PCKG_SZ  pushed data; the same packet is driven to all lanes.
- grant_id  out  $clog2(DRVRS)  last granted source index.
- busy  out  1  high whenever the FSM is not in IDLE.

Behaviour:
Reset values (while reset = 0, async):
- pop = 0, push = 0, D_pop capture register = 0, grant_id = 0, busy = 0.
- Round-robin pointer rr_ptr = 0; FSM = IDLE.

FSM states: IDLE, POP, PUSH.
- IDLE: if pndng != 0, pick the first i with pndng[i] = 1, searching from rr_ptr upward with wrap-around. Register grant_id = i, then go to POP. Otherwise stay in IDLE.
- POP (one cycle): pop[grant_id] = 1 and capture D_pop[grant_id] into pkt_q on this edge. Decode dest = pkt_q ID field. Go to PUSH.
- PUSH (one cycle):
  - dest == BCAST_ID: push[j] = 1 for all j != grant_id (no loopback).
  - dest < DRVRS and dest != grant_id: push[dest] = 1.
  - dest >= DRVRS (not broadcast) or dest == grant_id: no push; the packet is dropped.
  - rr_ptr <= (grant_id + 1) mod DRVRS. Go to IDLE.
- Latency: pndng sampled high at edge N gives pop high in cycle N+1 and push high in cycle N+2. One packet per 3 cycles maximum.
- Fairness: every pending driver is served within DRVRS grants.
- pndng dropping during POP: the pop still issues; the FIFO is responsible for underflow. The scheduler never aborts mid-transaction.
- A new pndng on any driver, including the granted one, during POP/PUSH is considered only at the next IDLE.
- Reset mid-operation: all strobes deassert immediately, the packet is discarded, and rr_ptr returns to 0.
- pop and push are never both high in the same cycle. push is never high on more than DRVRS-1 lanes.

Optional Feature:
- Macro BUS_SCHED_STATS_EN.
- When defined, adds output pkt_cnt (16 bits) and output drop_cnt (16 bits):
  - pkt_cnt increments once per PUSH state that delivers.
  - drop_cnt increments once per dropped packet.
  - Both saturate at 16'hFFFF and reset to 0.
- When undefined, neither port nor the counters exist.

Decomposition:
- Package bus_sched_pkg holds:
  - sched_state_e enum {IDLE, POP, PUSH};
  - default BCAST_ID constant;
  - function get_dest(pkt) extracting the ID field.
- One sub-module, rr_picker: combinational rotated priority encoder.
  - Inputs: req[DRVRS], ptr.
  - Outputs: gnt_idx, gnt_vld.
  - Instantiated once by bus_rr_sched.

Test Plan:
1. Reset low for 3 cycles, pndng = 8'hFF → pop, push = 0, busy = 0. After release, the first grant goes to driver 0.
2. pndng[2] = 1, D_pop[2] = 16'h05AB → pop[2] pulses in cycle N+1, push[5] pulses in N+2, D_push = 16'h05AB, grant_id = 2.
3. pndng[3] = 1, D_pop[3] = 16'hFF12 → push = 8'hF7 (all except lane 3) for exactly one cycle.
4. pndng = 8'hFF held, each D_pop addressed to (src+1)%8 → grant order 0,1,...,7,0 and one pop every 3 cycles.
5. D_pop[1] = 16'h0934 (dest 9 ≥ DRVRS) and D_pop[4] = 16'h0433 (dest == src) → no push. With BUS_SCHED_STATS_EN, drop_cnt = 2.
6. Reset asserted during the POP cycle → pop falls asynchronously with no subsequent push, and after release rr_ptr = 0.
